// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Sequences the single data-memory port behind the EX/MEM register. The port is
//   shared between the MEM-stage load/store and a DMA/loader requester. Memory
//   latency is variable. While a pipeline access is outstanding, StallM freezes the
//   pipeline up to and including EX/MEM.
//
// Ports
//   CLK, RST              clock (rising edge), synchronous active-high reset
//   MemReadM, MemWriteM   MEM-stage load / store request
//   ALUResultM            MEM-stage address
//   WriteDataM            MEM-stage store data
//   StallM                freeze pipeline registers up to and including EX/MEM
//   ReadDataM             load data to MEM/WB
//   DmaReq/DmaWE          DMA request (held until DmaAck) / write(1) read(0)
//   DmaAddr/DmaWData      DMA address / write data
//   DmaAck/DmaRData       one-cycle completion pulse / read data valid with DmaAck
//   MemReq/MemWE          memory request pulse / write enable
//   MemAddr/MemWData      memory address / write data, held for the whole access
//   MemRData/MemDone      memory read data / completion
//   BusErr                sticky access-timeout flag
module data_mem_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned STARVE_LIMIT  = 4,
    parameter int unsigned TIMEOUT       = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     MemReadM,
    input  logic                     MemWriteM,
    input  logic [ADDRESS_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0]    WriteDataM,
    output logic                     StallM,
    output logic [DATA_WIDTH-1:0]    ReadDataM,
    input  logic                     DmaReq,
    input  logic                     DmaWE,
    input  logic [ADDRESS_WIDTH-1:0] DmaAddr,
    input  logic [DATA_WIDTH-1:0]    DmaWData,
    output logic                     DmaAck,
    output logic [DATA_WIDTH-1:0]    DmaRData,
    output logic                     MemReq,
    output logic                     MemWE,
    output logic [ADDRESS_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0]    MemWData,
    input  logic [DATA_WIDTH-1:0]    MemRData,
    input  logic                     MemDone,
    output logic                     BusErr
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TOUT_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PIPE_WAIT = 2'd1,
        DMA_WAIT  = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [SW-1:0]           starve_cnt;
    logic [TW-1:0]           tout_cnt;
    logic [DATA_WIDTH-1:0]   rd_hold;
    logic [DATA_WIDTH-1:0]   dma_rdata;

    logic pipe_req;
    logic in_wait;
    logic timeout_hit;
    logic wait_end;
    logic dma_win;
    logic pipe_win;

    always_comb begin
        state_next  = state;
        pipe_req    = MemReadM | MemWriteM;
        in_wait     = (state != IDLE);
        // Timeout fires in the WAIT cycle that would bring the counter to TIMEOUT.
        timeout_hit = in_wait && !MemDone && (tout_cnt == TOUT_LAST);
        wait_end    = in_wait && (MemDone || timeout_hit);
        // A starved DMA overrides the pipeline; otherwise the pipeline has priority.
        dma_win     = (state == IDLE) && DmaReq && ((starve_cnt == STARVE_MAX) || !pipe_req);
        pipe_win    = (state == IDLE) && pipe_req && !dma_win;

        unique case (state)
            IDLE: begin
                if (dma_win)       state_next = DMA_WAIT;
                else if (pipe_win) state_next = PIPE_WAIT;
            end
            PIPE_WAIT, DMA_WAIT: begin
                if (wait_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        StallM = pipe_req & ~((state == PIPE_WAIT) & (MemDone | timeout_hit));

        ReadDataM = rd_hold;
        if (state == PIPE_WAIT) begin
            if (MemDone)          ReadDataM = MemRData;
            else if (timeout_hit) ReadDataM = '0;
        end
    end

    assign DmaRData = dma_rdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            MemReq     <= 1'b0;
            MemWE      <= 1'b0;
            MemAddr    <= '0;
            MemWData   <= '0;
            DmaAck     <= 1'b0;
            BusErr     <= 1'b0;
            starve_cnt <= '0;
            tout_cnt   <= '0;
            rd_hold    <= '0;
            dma_rdata  <= '0;
        end else begin
            state  <= state_next;
            MemReq <= dma_win | pipe_win;
            DmaAck <= (state == DMA_WAIT) && wait_end;

            if (dma_win) begin
                MemAddr  <= DmaAddr;
                MemWData <= DmaWData;
                MemWE    <= DmaWE;
            end else if (pipe_win) begin
                MemAddr  <= ALUResultM;
                MemWData <= WriteDataM;
                MemWE    <= MemWriteM;
            end

            if ((state == PIPE_WAIT) && wait_end)
                rd_hold <= MemDone ? MemRData : '0;
            if ((state == DMA_WAIT) && wait_end)
                dma_rdata <= MemDone ? MemRData : '0;

            if (timeout_hit)
                BusErr <= 1'b1;

            if (in_wait && !wait_end)
                tout_cnt <= tout_cnt + 1'b1;
            else
                tout_cnt <= '0;

            // The DMA being serviced counts as granted, so it does not accumulate
            // starvation while its own access is in flight.
            if (!DmaReq || dma_win || (state == DMA_WAIT))
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

    localparam int LIM = 4;
    localparam int TO  = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MemReadM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        DmaReq, DmaWE;
    logic [31:0] DmaAddr, DmaWData;
    logic        DmaAck;
    logic [31:0] DmaRData;
    logic        MemReq, MemWE;
    logic [31:0] MemAddr, MemWData;
    logic [31:0] MemRData;
    logic        MemDone;
    logic        BusErr;

    data_mem_arbiter #(
        .DATA_WIDTH(32),
        .ADDRESS_WIDTH(32),
        .STARVE_LIMIT(LIM),
        .TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .RST(RST),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .StallM(StallM), .ReadDataM(ReadDataM),
        .DmaReq(DmaReq), .DmaWE(DmaWE), .DmaAddr(DmaAddr), .DmaWData(DmaWData),
        .DmaAck(DmaAck), .DmaRData(DmaRData),
        .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData), .MemDone(MemDone),
        .BusErr(BusErr)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference model: who owns the port (0 none, 1 pipeline, 2 DMA), how long
    // the access has waited, and the values the port and requesters should see.
    int          m_owner;
    bit          m_first;
    int          m_age;
    int          m_starve;
    bit          m_berr;
    bit          m_ack;
    logic [31:0] m_addr, m_wdata, m_hold, m_dmar;
    bit          m_we;

    // Memory responder and stimulus control.
    bit dir_mode;
    int lat_force;
    bit spur_force;
    bit pend;
    int rem;
    bit prev_stall;

    // Last observed values, for directed spot checks.
    logic        last_stall, last_memreq, last_ack, last_we, last_berr;
    logic [31:0] last_rd, last_addr, last_dmar;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_first = 0; m_age = 0; m_starve = 0; m_berr = 0; m_ack = 0;
        m_addr = '0; m_wdata = '0; m_hold = '0; m_dmar = '0; m_we = 0;
    endtask

    function automatic int sat_inc(input int v);
        return (v + 1 > LIM) ? LIM : v + 1;
    endfunction

    function automatic int pick_lat();
        if (lat_force >= 0) return lat_force;
        if ($urandom % 40 == 0) return 99;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic model_edge();
        bit          pipe, nack, was_dma;
        logic [31:0] d;
        if (RST) begin
            model_reset();
            return;
        end
        pipe = MemReadM | MemWriteM;
        nack = 0;
        if (m_owner == 0) begin
            if (DmaReq && (m_starve == LIM || !pipe)) begin
                m_owner = 2; m_first = 1;
                m_addr = DmaAddr; m_wdata = DmaWData; m_we = DmaWE;
                m_starve = 0;
            end else begin
                if (pipe) begin
                    m_owner = 1; m_first = 1;
                    m_addr = ALUResultM; m_wdata = WriteDataM; m_we = MemWriteM;
                end
                m_starve = DmaReq ? sat_inc(m_starve) : 0;
            end
        end else begin
            m_first = 0;
            was_dma = (m_owner == 2);
            if (MemDone || m_age == TO - 1) begin
                d = MemDone ? MemRData : 32'h0;
                if (m_owner == 1) m_hold = d;
                else begin nack = 1; m_dmar = d; end
                if (!MemDone) m_berr = 1;
                m_owner = 0;
                m_age = 0;
            end else begin
                m_age++;
            end
            m_starve = (was_dma || !DmaReq) ? 0 : sat_inc(m_starve);
        end
        m_ack = nack;
    endtask

    // One clock: drive the memory response, check every output against the
    // model, then advance the model across the edge.
    task automatic cyc();
        bit          pipe, tnow, e_stall;
        logic [31:0] e_rd;
        if (m_ack) DmaReq = 1'b0;
        if (m_owner == 0) pend = 0;
        if (m_owner != 0 && m_first) begin pend = 1; rem = pick_lat(); end
        if (pend) MemDone = (rem == 0);
        else      MemDone = spur_force || (!dir_mode && ($urandom % 8 == 0));
        if (pend && rem > 0) rem--;
        #2;
        pipe    = MemReadM | MemWriteM;
        tnow    = (m_owner != 0) && !MemDone && (m_age == TO - 1);
        e_stall = pipe && !(m_owner == 1 && (MemDone || tnow));
        if (m_owner == 1 && MemDone)   e_rd = MemRData;
        else if (m_owner == 1 && tnow) e_rd = 32'h0;
        else                           e_rd = m_hold;
        chk("StallM",   {31'b0, StallM}, {31'b0, e_stall});
        chk("ReadDataM", ReadDataM, e_rd);
        chk("MemReq",   {31'b0, MemReq}, {31'b0, (m_owner != 0) && m_first});
        chk("MemAddr",  MemAddr, m_addr);
        chk("MemWData", MemWData, m_wdata);
        chk("MemWE",    {31'b0, MemWE}, {31'b0, m_we});
        chk("DmaAck",   {31'b0, DmaAck}, {31'b0, m_ack});
        chk("DmaRData", DmaRData, m_dmar);
        chk("BusErr",   {31'b0, BusErr}, {31'b0, m_berr});
        last_stall = StallM; last_memreq = MemReq; last_ack = DmaAck; last_we = MemWE;
        last_berr = BusErr; last_rd = ReadDataM; last_addr = MemAddr; last_dmar = DmaRData;
        prev_stall = e_stall;
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic rand_inputs();
        int r;
        RST = ($urandom % 300 == 0);
        if (!prev_stall) begin
            r = int'($urandom % 4);
            MemReadM   = (r == 1);
            MemWriteM  = (r == 2);
            ALUResultM = $urandom;
            WriteDataM = $urandom;
        end
        if (!DmaReq && !m_ack && ($urandom % 3 == 0)) begin
            DmaReq   = 1'b1;
            DmaWE    = $urandom % 2;
            DmaAddr  = $urandom;
            DmaWData = $urandom;
        end
        MemRData = $urandom;
    endtask

    task automatic reset_pulse();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        MemReadM = 0; MemWriteM = 0; ALUResultM = '0; WriteDataM = '0;
        DmaReq = 0; DmaWE = 0; DmaAddr = '0; DmaWData = '0;
        MemRData = '0; MemDone = 0;
        dir_mode = 1; lat_force = 0; spur_force = 0; pend = 0; rem = 0; prev_stall = 0;
        @(posedge CLK);
        model_reset();
        #1;
        cyc();
        chk("reset_memreq", {31'b0, last_memreq}, 32'h0);
        chk("reset_addr",   last_addr, 32'h0);
        RST = 1'b0;

        // Load, zero latency after MemReq.
        MemReadM = 1; ALUResultM = 32'h100; MemRData = 32'hDEADBEEF; lat_force = 0;
        cyc();
        chk("t1_stall_c0", {31'b0, last_stall}, 32'h1);
        cyc();
        chk("t1_memreq", {31'b0, last_memreq}, 32'h1);
        chk("t1_addr",   last_addr, 32'h100);
        chk("t1_stall",  {31'b0, last_stall}, 32'h0);
        chk("t1_rdata",  last_rd, 32'hDEADBEEF);
        MemReadM = 0;
        cyc();

        // Store, done 3 cycles after MemReq.
        MemWriteM = 1; ALUResultM = 32'h40; WriteDataM = 32'h12345678; lat_force = 3;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t2_stall_hi", {31'b0, last_stall}, 32'h1);
        end
        cyc();
        chk("t2_stall_done", {31'b0, last_stall}, 32'h0);
        chk("t2_wdata", last_addr == 32'h40 ? MemWData : 32'hX, 32'h12345678);
        MemWriteM = 0;
        cyc();

        // Pipeline hammering plus DMA: DMA wins once starvation saturates.
        reset_pulse();
        MemReadM = 1; ALUResultM = 32'h10; lat_force = 0;
        DmaReq = 1; DmaWE = 1; DmaAddr = 32'h7000; DmaWData = 32'h55;
        for (int i = 0; i < 5; i++) cyc();
        cyc();
        chk("t3_dma_addr",   last_addr, 32'h7000);
        chk("t3_dma_memreq", {31'b0, last_memreq}, 32'h1);
        chk("t3_pipe_stall", {31'b0, last_stall}, 32'h1);
        cyc();
        chk("t3_dma_ack", {31'b0, last_ack}, 32'h1);
        MemReadM = 0;
        cyc(); cyc();

        // Load that never completes: timeout.
        reset_pulse();
        MemReadM = 1; ALUResultM = 32'h300; lat_force = 99;
        for (int i = 0; i < 17; i++) cyc();
        chk("t4_stall", {31'b0, last_stall}, 32'h0);
        chk("t4_rdata", last_rd, 32'h0);
        MemReadM = 0;
        cyc();
        chk("t4_berr", {31'b0, last_berr}, 32'h1);
        cyc(); cyc();
        chk("t4_berr_sticky", {31'b0, last_berr}, 32'h1);

        // Reset mid PIPE_WAIT, late MemDone after reset.
        MemReadM = 1; ALUResultM = 32'h88; lat_force = 99;
        cyc(); cyc();
        reset_pulse();
        spur_force = 1; lat_force = 0;
        cyc();
        chk("t5_memreq", {31'b0, last_memreq}, 32'h0);
        chk("t5_ack",    {31'b0, last_ack}, 32'h0);
        chk("t5_berr",   {31'b0, last_berr}, 32'h0);
        spur_force = 0;
        cyc();
        chk("t5_regrant", {31'b0, last_memreq}, 32'h1);
        chk("t5_addr",    last_addr, 32'h88);
        MemReadM = 0;
        cyc();

        // DMA read without pipeline traffic.
        DmaReq = 1; DmaWE = 0; DmaAddr = 32'h200; MemRData = 32'hA5A5A5A5; lat_force = 1;
        cyc();
        cyc();
        chk("t6_memreq", {31'b0, last_memreq}, 32'h1);
        chk("t6_addr",   last_addr, 32'h200);
        cyc();
        cyc();
        chk("t6_ack",   {31'b0, last_ack}, 32'h1);
        chk("t6_rdata", last_dmar, 32'hA5A5A5A5);
        chk("t6_stall", {31'b0, last_stall}, 32'h0);

        // Randomised traffic against the model.
        dir_mode = 0; lat_force = -1;
        for (int i = 0; i < 4000; i++) begin
            rand_inputs();
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
